// File: rtl/flash_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : flash_bus_ctrl
//  Description : Flash-side responder for the manager's FL_TRG/FL_STATUS
//                handshake. Turns each request into a one-byte read or a
//                0x40 program (with status polling and read-array restore)
//                on an 8-bit Intel-style parallel flash.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_bus_ctrl #(
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-9:0] ADDR_BASE = '0,
    parameter int                T_ACC     = 6,
    parameter int                T_WP      = 4,
    parameter int                T_REC     = 2,
    parameter int                POLL_MAX  = 50000
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              FL_TRG,
    input  logic              FL_FLOW,
    input  logic [7:0]        FL_ADDR,
    input  logic [7:0]        fl_data_in,
    output logic [7:0]        fl_data_out,
    output logic              FL_STATUS,
    output logic              fl_err,
    output logic [ADDR_W-1:0] SF_A,
    output logic [7:0]        SF_D_O,
    input  logic [7:0]        SF_D_I,
    output logic              SF_D_OE,
    output logic              SF_CE_N,
    output logic              SF_OE_N,
    output logic              SF_WE_N
);

    // Timing counter must hold the longest strobe phase; poll counter must hold POLL_MAX.
    localparam int c_tmax_ab = (T_ACC > T_WP) ? T_ACC : T_WP;
    localparam int c_tmax    = (c_tmax_ab > T_REC) ? c_tmax_ab : T_REC;
    localparam int c_cnt_w   = $clog2(c_tmax + 1);
    localparam int c_poll_w  = $clog2(POLL_MAX + 1);

    localparam logic [c_cnt_w-1:0]  c_acc_last = c_cnt_w'(T_ACC - 1);
    localparam logic [c_cnt_w-1:0]  c_wp_last  = c_cnt_w'(T_WP - 1);
    localparam logic [c_cnt_w-1:0]  c_rec_last = c_cnt_w'(T_REC - 1);
    localparam logic [c_poll_w-1:0] c_poll_max = c_poll_w'(POLL_MAX);
    localparam logic [7:0]          c_cmd_prog = 8'h40;
    localparam logic [7:0]          c_cmd_rda  = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RD   = 4'd1,
        S_WCMD = 4'd2,
        S_WDAT = 4'd3,
        S_GAP  = 4'd4,
        S_PRD  = 4'd5,
        S_CLR  = 4'd6,
        S_REC1 = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t              r_state, w_state_nxt;
    state_t              r_gap_ret, w_gap_ret_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [c_poll_w-1:0] r_poll, w_poll_nxt, w_poll_inc;
    logic                r_err, w_err_nxt;
    logic [7:0]          r_dout, w_dout_nxt;
    logic                w_accept;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic                r_status, r_fl_err;
    logic                r_ce_n, r_oe_n, r_we_n, r_d_oe;
    logic [7:0]          r_d_o;
    logic                w_ce_n, w_oe_n, w_we_n, w_d_oe;
    logic [7:0]          w_d_o;

    assign w_poll_inc = r_poll + 1'b1;

    // State register and all registered outputs; strobes are registered from the next state
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_gap_ret <= S_IDLE;
            r_cnt     <= '0;
            r_poll    <= '0;
            r_err     <= 1'b0;
            r_dout    <= 8'h00;
            r_addr    <= '0;
            r_wdata   <= 8'h00;
            r_status  <= 1'b0;
            r_fl_err  <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_d_oe    <= 1'b0;
            r_d_o     <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_ret <= w_gap_ret_nxt;
            r_cnt     <= w_cnt_nxt;
            r_poll    <= w_poll_nxt;
            r_err     <= w_err_nxt;
            r_dout    <= w_dout_nxt;
            if (w_accept) begin
                r_addr  <= {ADDR_BASE, FL_ADDR};
                r_wdata <= fl_data_in;
            end
            r_status  <= (r_state == S_DONE);
            r_fl_err  <= (r_state == S_DONE) && r_err;
            r_ce_n    <= w_ce_n;
            r_oe_n    <= w_oe_n;
            r_we_n    <= w_we_n;
            r_d_oe    <= w_d_oe;
            r_d_o     <= w_d_o;
        end
    end

    // Next-state, phase timing, poll/error bookkeeping and next bus strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_ret_nxt = r_gap_ret;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_poll_nxt    = r_poll;
        w_err_nxt     = r_err;
        w_dout_nxt    = r_dout;
        w_accept      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (FL_TRG) begin
                    w_accept    = 1'b1;
                    w_poll_nxt  = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = FL_FLOW ? S_WCMD : S_RD;
                end
            end
            S_RD: begin
                if (r_cnt == c_acc_last) begin
                    w_dout_nxt  = SF_D_I;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REC1;
                end
            end
            S_WCMD: begin
                if (r_cnt == c_wp_last) begin
                    w_cnt_nxt     = '0;
                    w_gap_ret_nxt = S_WDAT;
                    w_state_nxt   = S_GAP;
                end
            end
            S_WDAT: begin
                if (r_cnt == c_wp_last) begin
                    w_cnt_nxt     = '0;
                    w_gap_ret_nxt = S_PRD;
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == c_rec_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_gap_ret;
                end
            end
            S_PRD: begin
                if (r_cnt == c_acc_last) begin
                    w_cnt_nxt   = '0;
                    w_poll_nxt  = w_poll_inc;
                    w_state_nxt = S_GAP;
                    if (SF_D_I[7]) begin
                        w_err_nxt     = SF_D_I[4];
                        w_gap_ret_nxt = S_CLR;
                    end else if (w_poll_inc == c_poll_max) begin
                        w_err_nxt     = 1'b1;
                        w_gap_ret_nxt = S_CLR;
                    end else begin
                        w_gap_ret_nxt = S_PRD;
                    end
                end
            end
            S_CLR: begin
                if (r_cnt == c_wp_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REC1;
                end
            end
            S_REC1: begin
                if (r_cnt == c_rec_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_cnt_nxt   = '0;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Drive DQ only while WE# is low so the flash and FPGA never contend
        w_ce_n = 1'b1;
        w_oe_n = 1'b1;
        w_we_n = 1'b1;
        w_d_oe = 1'b0;
        w_d_o  = 8'h00;
        case (w_state_nxt)
            S_RD, S_PRD: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
            end
            S_WCMD: begin
                w_ce_n = 1'b0;
                w_we_n = 1'b0;
                w_d_oe = 1'b1;
                w_d_o  = c_cmd_prog;
            end
            S_WDAT: begin
                w_ce_n = 1'b0;
                w_we_n = 1'b0;
                w_d_oe = 1'b1;
                w_d_o  = r_wdata;
            end
            S_CLR: begin
                w_ce_n = 1'b0;
                w_we_n = 1'b0;
                w_d_oe = 1'b1;
                w_d_o  = c_cmd_rda;
            end
            default: begin
                w_ce_n = 1'b1;
            end
        endcase
    end

    assign fl_data_out = r_dout;
    assign FL_STATUS   = r_status;
    assign fl_err      = r_fl_err;
    assign SF_A        = r_addr;
    assign SF_D_O      = r_d_o;
    assign SF_D_OE     = r_d_oe;
    assign SF_CE_N     = r_ce_n;
    assign SF_OE_N     = r_oe_n;
    assign SF_WE_N     = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_flash_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_bus_ctrl
//  Description : Directed self-checking bench for flash_bus_ctrl with a small
//                behavioural flash (array/status modes, programmable SR).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        FL_TRG = 1'b0;
    logic        FL_FLOW = 1'b0;
    logic [7:0]  FL_ADDR = 8'h00;
    logic [7:0]  fl_data_in = 8'h00;
    logic [7:0]  fl_data_out;
    logic        FL_STATUS, fl_err;
    logic [23:0] SF_A;
    logic [7:0]  SF_D_O, SF_D_I;
    logic        SF_D_OE, SF_CE_N, SF_OE_N, SF_WE_N;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flash_bus_ctrl #(
        .ADDR_W(24), .ADDR_BASE(16'h0000), .T_ACC(6), .T_WP(4), .T_REC(2), .POLL_MAX(4)
    ) dut (
        .CLK_50MHZ(clk), .RST(rst),
        .FL_TRG(FL_TRG), .FL_FLOW(FL_FLOW), .FL_ADDR(FL_ADDR), .fl_data_in(fl_data_in),
        .fl_data_out(fl_data_out), .FL_STATUS(FL_STATUS), .fl_err(fl_err),
        .SF_A(SF_A), .SF_D_O(SF_D_O), .SF_D_I(SF_D_I), .SF_D_OE(SF_D_OE),
        .SF_CE_N(SF_CE_N), .SF_OE_N(SF_OE_N), .SF_WE_N(SF_WE_N)
    );

    // ---------------- flash model ----------------
    logic [7:0] wlog[$];
    bit         status_mode = 1'b0;
    bit         expect_data = 1'b0;
    bit         prog_done = 1'b0;
    logic [7:0] prog_addr = 8'h00;
    logic [7:0] prog_byte = 8'h00;
    logic [7:0] held_d = 8'h00;
    logic       prev_we = 1'b1;
    logic       prev_oe = 1'b1;
    int         poll_cnt = 0;
    int         viol = 0;
    int         poll_base = 0;
    int         ready_after = 1;
    logic [7:0] sr_ready_val = 8'h80;

    assign SF_D_I = status_mode ? (((poll_cnt - poll_base) >= ready_after) ? sr_ready_val : 8'h00)
                  : ((prog_done && SF_A[7:0] == prog_addr) ? prog_byte
                  : ((SF_A[7:0] == 8'h12) ? 8'hA5 : 8'h00));

    // Flash bus monitor: completes writes on WE# rise, counts status reads, flags contention
    always @(negedge clk) begin
        if (!rst) begin
            if ((!SF_WE_N && !SF_OE_N) || (SF_D_OE && SF_WE_N)) viol <= viol + 1;
            if (!SF_WE_N) held_d <= SF_D_O;
            if (!prev_we && SF_WE_N) begin
                wlog.push_back(held_d);
                if (expect_data) begin
                    prog_byte   <= held_d;
                    prog_addr   <= SF_A[7:0];
                    prog_done   <= 1'b1;
                    status_mode <= 1'b1;
                    expect_data <= 1'b0;
                end else if (held_d == 8'h40) begin
                    expect_data <= 1'b1;
                end else if (held_d == 8'hFF) begin
                    status_mode <= 1'b0;
                end
            end
            if (prev_oe && !SF_OE_N && status_mode) poll_cnt <= poll_cnt + 1;
        end
        prev_we <= SF_WE_N;
        prev_oe <= SF_OE_N;
    end

    // ---------------- request driver ----------------
    task automatic do_req(input bit flow, input logic [7:0] addr, input logic [7:0] data,
                          input int pulse_at,
                          output int lat, output int oe_low, output int n_status,
                          output logic err, output logic [7:0] dout, output logic [23:0] sfa,
                          output int nwr, output int npoll, output int wbase);
        int base_p;
        @(negedge clk);
        wbase     = wlog.size();
        poll_base = poll_cnt;
        base_p    = poll_cnt;
        FL_TRG = 1'b1; FL_FLOW = flow; FL_ADDR = addr; fl_data_in = data;
        @(posedge clk); #1;
        FL_TRG = 1'b0; FL_ADDR = 8'h00; fl_data_in = 8'h00;
        lat = -1; n_status = 0; err = 1'b0; dout = 8'h00;
        sfa = SF_A;
        oe_low = !SF_OE_N ? 1 : 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            FL_TRG = (n == pulse_at);
            if (!SF_OE_N) oe_low++;
            if (FL_STATUS) begin
                n_status++;
                if (lat < 0) begin
                    lat = n; err = fl_err; dout = fl_data_out;
                end
            end
            if (lat >= 0 && n >= lat + 12) break;
        end
        FL_TRG = 1'b0;
        nwr   = wlog.size() - wbase;
        npoll = poll_cnt - base_p;
    endtask

    int lat, oe_low, nst, nwr, npoll, wb;
    logic err;
    logic [7:0] dout;
    logic [23:0] sfa;

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({SF_CE_N, SF_OE_N, SF_WE_N, SF_D_OE} !== 4'b1110) begin
            failures++; $display("FAIL reset_strobes got=%b want=1110", {SF_CE_N, SF_OE_N, SF_WE_N, SF_D_OE});
        end
        checks++;
        if (SF_A !== 24'h0 || SF_D_O !== 8'h00) begin
            failures++; $display("FAIL reset_bus got A=%h D=%h want 0/0", SF_A, SF_D_O);
        end
        checks++;
        if ({FL_STATUS, fl_err, fl_data_out} !== 10'h0) begin
            failures++; $display("FAIL reset_outs got st=%b err=%b dout=%h want 0", FL_STATUS, fl_err, fl_data_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        do_req(1'b0, 8'h12, 8'h00, 0, lat, oe_low, nst, err, dout, sfa, nwr, npoll, wb);
        checks++; if (sfa !== 24'h000012) begin failures++; $display("FAIL read_addr got=%h want=000012", sfa); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL read_latency got=%0d want=9", lat); end
        checks++; if (oe_low !== 6) begin failures++; $display("FAIL read_oe_cycles got=%0d want=6", oe_low); end
        checks++; if (dout !== 8'hA5 || err !== 1'b0) begin failures++; $display("FAIL read_data got=%h err=%b want=a5 err=0", dout, err); end
        checks++; if (nst !== 1 || nwr !== 0) begin failures++; $display("FAIL read_counts got st=%0d wr=%0d want 1/0", nst, nwr); end
    endtask

    task automatic test_program();
        ready_after = 3; sr_ready_val = 8'h80;
        do_req(1'b1, 8'h34, 8'h5A, 0, lat, oe_low, nst, err, dout, sfa, nwr, npoll, wb);
        checks++; if (lat !== 43) begin failures++; $display("FAIL prog_latency got=%0d want=43", lat); end
        checks++; if (npoll !== 3 || oe_low !== 18) begin failures++; $display("FAIL prog_polls got=%0d oe=%0d want 3/18", npoll, oe_low); end
        checks++;
        if (nwr !== 3) begin failures++; $display("FAIL prog_nwrites got=%0d want=3", nwr); end
        else if (wlog[wb] !== 8'h40 || wlog[wb+1] !== 8'h5A || wlog[wb+2] !== 8'hFF) begin
            failures++; $display("FAIL prog_writes got=%h %h %h want=40 5a ff", wlog[wb], wlog[wb+1], wlog[wb+2]);
        end
        checks++; if (err !== 1'b0 || nst !== 1) begin failures++; $display("FAIL prog_status got err=%b st=%0d want 0/1", err, nst); end
        checks++; if (prog_addr !== 8'h34) begin failures++; $display("FAIL prog_addr got=%h want=34", prog_addr); end
        do_req(1'b0, 8'h34, 8'h00, 0, lat, oe_low, nst, err, dout, sfa, nwr, npoll, wb);
        checks++; if (dout !== 8'h5A) begin failures++; $display("FAIL prog_readback got=%h want=5a", dout); end
    endtask

    task automatic test_prog_error();
        ready_after = 1; sr_ready_val = 8'h90;
        do_req(1'b1, 8'h56, 8'h77, 0, lat, oe_low, nst, err, dout, sfa, nwr, npoll, wb);
        checks++; if (npoll !== 1) begin failures++; $display("FAIL perr_polls got=%0d want=1", npoll); end
        checks++; if (err !== 1'b1 || lat !== 27) begin failures++; $display("FAIL perr_status got err=%b lat=%0d want 1/27", err, lat); end
        checks++;
        if (nwr !== 3) begin failures++; $display("FAIL perr_nwrites got=%0d want=3", nwr); end
        else if (wlog[wb+2] !== 8'hFF) begin failures++; $display("FAIL perr_clr got=%h want=ff", wlog[wb+2]); end
    endtask

    task automatic test_timeout();
        ready_after = 1000; sr_ready_val = 8'h80;
        do_req(1'b1, 8'h78, 8'h3C, 0, lat, oe_low, nst, err, dout, sfa, nwr, npoll, wb);
        checks++; if (npoll !== 4) begin failures++; $display("FAIL tmo_polls got=%0d want=4", npoll); end
        checks++; if (err !== 1'b1 || lat !== 51 || nst !== 1) begin failures++; $display("FAIL tmo_status got err=%b lat=%0d st=%0d want 1/51/1", err, lat, nst); end
        checks++;
        if (nwr !== 3) begin failures++; $display("FAIL tmo_nwrites got=%0d want=3", nwr); end
        else if (wlog[wb+2] !== 8'hFF) begin failures++; $display("FAIL tmo_clr got=%h want=ff", wlog[wb+2]); end
    endtask

    task automatic test_busy();
        do_req(1'b0, 8'h12, 8'h00, 2, lat, oe_low, nst, err, dout, sfa, nwr, npoll, wb);
        checks++; if (nst !== 1) begin failures++; $display("FAIL busy_status_count got=%0d want=1", nst); end
        checks++; if (lat !== 9 || dout !== 8'hA5) begin failures++; $display("FAIL busy_read got lat=%0d d=%h want 9/a5", lat, dout); end
    endtask

    task automatic test_back_to_back();
        int first, second, total;
        first = -1; second = -1; total = 0;
        @(negedge clk);
        FL_TRG = 1'b1; FL_FLOW = 1'b0; FL_ADDR = 8'h12;
        @(posedge clk); #1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (FL_STATUS) begin
                total++;
                if (first < 0) first = n;
                else if (second < 0) begin second = n; FL_TRG = 1'b0; end
            end
        end
        FL_TRG = 1'b0;
        checks++; if (first !== 9 || second !== 19) begin failures++; $display("FAIL b2b_timing got=%0d,%0d want=9,19", first, second); end
        checks++; if (total !== 2 || fl_data_out !== 8'hA5) begin failures++; $display("FAIL b2b_total got=%0d d=%h want 2/a5", total, fl_data_out); end
    endtask

    task automatic test_async_reset();
        ready_after = 3; sr_ready_val = 8'h80;
        @(negedge clk);
        FL_TRG = 1'b1; FL_FLOW = 1'b1; FL_ADDR = 8'h40; fl_data_in = 8'h11;
        @(posedge clk); #1;
        FL_TRG = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        checks++;
        if (SF_WE_N !== 1'b0 || SF_D_OE !== 1'b1 || SF_D_O !== 8'h11) begin
            failures++; $display("FAIL ares_in_wdat got we=%b oe=%b d=%h want 0/1/11", SF_WE_N, SF_D_OE, SF_D_O);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({SF_CE_N, SF_OE_N, SF_WE_N, SF_D_OE} !== 4'b1110) begin
            failures++; $display("FAIL ares_strobes got=%b want=1110", {SF_CE_N, SF_OE_N, SF_WE_N, SF_D_OE});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 8'h12, 8'h00, 0, lat, oe_low, nst, err, dout, sfa, nwr, npoll, wb);
        checks++; if (lat !== 9 || dout !== 8'hA5 || nst !== 1) begin failures++; $display("FAIL ares_read got lat=%0d d=%h st=%0d want 9/a5/1", lat, dout, nst); end
    endtask

    task automatic test_bus_rules();
        checks++; if (viol !== 0) begin failures++; $display("FAIL bus_rules got=%0d violations want=0", viol); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_program();
        test_prog_error();
        test_timeout();
        test_busy();
        test_back_to_back();
        test_async_reset();
        test_bus_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
